paddle_bbox_tracker: RTL and testbench

- Consumes the 1-bit merged edge/colour-mask pixel stream from the merge stage, one pixel per valid cycle, in raster order.
- Accumulates a per-frame bounding box and set-pixel count for the paddle, restricted to a row region of interest.
- At frame end it publishes the box, its centre and a found flag to the game/overlay logic.

---
 rtl/paddle_loc_pkg.sv | 35 +++
 rtl/raster_position_counter.sv | 48 ++++
 rtl/paddle_bbox_tracker.sv | 115 +++++++++++
 tb/tb_paddle_bbox_tracker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/paddle_loc_pkg.sv
// Shared types and defaults for the paddle-localization pipeline stages.
package paddle_loc_pkg;

    localparam int unsigned DEF_WIDTH  = 640;
    localparam int unsigned DEF_HEIGHT = 480;
    localparam int unsigned DEF_COL_W  = $clog2(DEF_WIDTH);
    localparam int unsigned DEF_ROW_W  = $clog2(DEF_HEIGHT);

    // Box fields are sized generously so one struct serves every frame geometry.
    localparam int unsigned BOX_W     = 16;
    localparam int unsigned BOX_CNT_W = 32;

    typedef struct packed {
        logic [BOX_W-1:0]     x_min;
        logic [BOX_W-1:0]     x_max;
        logic [BOX_W-1:0]     y_min;
        logic [BOX_W-1:0]     y_max;
        logic [BOX_CNT_W-1:0] count;
    } bbox_t;

    typedef enum logic [1:0] {
        ACCUM   = 2'b01,
        PUBLISH = 2'b10
    } tracker_state_t;

    // Empty box: min trackers at their sentinels so the first hit overwrites them.
    function automatic bbox_t bbox_init(input int unsigned width, input int unsigned height);
        bbox_t b;
        b       = '0;
        b.x_min = BOX_W'(width - 1);
        b.y_min = BOX_W'(height - 1);
        return b;
    endfunction

endpackage

// File: rtl/raster_position_counter.sv
// Raster col/row tracker for a valid-qualified pixel stream with sof resync.
module raster_position_counter
    import paddle_loc_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned COL_W  = DEF_COL_W,
    parameter int unsigned ROW_W  = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [COL_W-1:0] col_c,
    output logic [ROW_W-1:0] row_c,
    output logic             end_of_frame_c
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             sof_c;

    // A qualified sof relabels the current pixel as (0,0) and suppresses end-of-frame.
    assign sof_c          = in_valid && in_sof;
    assign col_c          = sof_c ? '0 : col_q;
    assign row_c          = sof_c ? '0 : row_q;
    assign end_of_frame_c = in_valid && !in_sof && (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Advance the position only on valid pixels, wrapping col then row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            if (col_c == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_c == ROW_LAST) ? '0 : row_c + ROW_W'(1);
            end else begin
                col_q <= col_c + COL_W'(1);
                row_q <= row_c;
            end
        end
    end

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Per-frame bounding box / pixel count of the paddle mask, published at frame end.
module paddle_bbox_tracker
    import paddle_loc_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned HEIGHT     = DEF_HEIGHT,
    parameter int unsigned COL_W      = $clog2(WIDTH),
    parameter int unsigned ROW_W      = $clog2(HEIGHT),
    parameter int unsigned CNT_W      = 19,
    parameter int          ROI_Y_MIN  = 0,
    parameter int          ROI_Y_MAX  = int'(HEIGHT) - 1,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_pixel,
    input  logic             in_sof,
    output logic             frame_done,
    output logic             found,
    output logic [COL_W-1:0] x_min,
    output logic [COL_W-1:0] x_max,
    output logic [ROW_W-1:0] y_min,
    output logic [ROW_W-1:0] y_max,
    output logic [COL_W-1:0] x_ctr,
    output logic [ROW_W-1:0] y_ctr,
    output logic [CNT_W-1:0] pix_count
);

    localparam int unsigned XS_W = COL_W + 1;
    localparam int unsigned YS_W = ROW_W + 1;
    localparam logic [BOX_CNT_W-1:0] CNT_MAX = BOX_CNT_W'({CNT_W{1'b1}});
    localparam bbox_t BOX_EMPTY = bbox_init(WIDTH, HEIGHT);

    tracker_state_t   state;
    bbox_t            acc;
    bbox_t            next_c;
    logic [COL_W-1:0] col_c;
    logic [ROW_W-1:0] row_c;
    logic             eof_c;
    logic             hit_c;
    logic             found_c;
    logic [XS_W-1:0]  x_sum_c;
    logic [YS_W-1:0]  y_sum_c;

    raster_position_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .col_c         (col_c),
        .row_c         (row_c),
        .end_of_frame_c(eof_c)
    );

    assign hit_c = in_valid && in_pixel &&
                   (int'(row_c) >= ROI_Y_MIN) && (int'(row_c) <= ROI_Y_MAX);

    // Box including the current pixel; sof starts from an empty box first.
    always_comb begin
        next_c = (in_valid && in_sof) ? BOX_EMPTY : acc;
        if (hit_c) begin
            if (BOX_W'(col_c) < next_c.x_min) next_c.x_min = BOX_W'(col_c);
            if (BOX_W'(col_c) > next_c.x_max) next_c.x_max = BOX_W'(col_c);
            if (BOX_W'(row_c) < next_c.y_min) next_c.y_min = BOX_W'(row_c);
            if (BOX_W'(row_c) > next_c.y_max) next_c.y_max = BOX_W'(row_c);
            if (next_c.count != CNT_MAX) next_c.count = next_c.count + BOX_CNT_W'(1);
        end
    end

    assign found_c = next_c.count >= BOX_CNT_W'(MIN_PIXELS);
    assign x_sum_c = XS_W'(next_c.x_min) + XS_W'(next_c.x_max);
    assign y_sum_c = YS_W'(next_c.y_min) + YS_W'(next_c.y_max);
    assign frame_done = (state == PUBLISH);

    // FSM, accumulator and result registers; the box holds when too few pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= BOX_EMPTY;
            found     <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            x_ctr     <= '0;
            y_ctr     <= '0;
            pix_count <= '0;
        end else begin
            case (state)
                ACCUM, PUBLISH: state <= eof_c ? PUBLISH : ACCUM;
                default:        state <= ACCUM;
            endcase
            acc <= eof_c ? BOX_EMPTY : next_c;
            if (eof_c) begin
                found     <= found_c;
                pix_count <= CNT_W'(next_c.count);
                if (found_c) begin
                    x_min <= COL_W'(next_c.x_min);
                    x_max <= COL_W'(next_c.x_max);
                    y_min <= ROW_W'(next_c.y_min);
                    y_max <= ROW_W'(next_c.y_max);
                    x_ctr <= x_sum_c[XS_W-1:1];
                    y_ctr <= y_sum_c[YS_W-1:1];
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_bbox_tracker.sv
// Directed bench: 8x6 frames, full-ROI and rows-2..3-ROI instances on one stream.
module tb_paddle_bbox_tracker;

    logic clk = 1'b0;
    logic reset, in_valid, in_pixel, in_sof;

    logic       frame_done, found;
    logic [2:0] x_min, x_max, y_min, y_max, x_ctr, y_ctr;
    logic [18:0] pix_count;

    logic       r_frame_done, r_found;
    logic [2:0] r_x_min, r_x_max, r_y_min, r_y_max, r_x_ctr, r_y_ctr;
    logic [18:0] r_pix_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddle_bbox_tracker #(.WIDTH(8), .HEIGHT(6), .MIN_PIXELS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
        .frame_done(frame_done), .found(found), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .x_ctr(x_ctr), .y_ctr(y_ctr), .pix_count(pix_count)
    );

    paddle_bbox_tracker #(.WIDTH(8), .HEIGHT(6), .MIN_PIXELS(2),
                          .ROI_Y_MIN(2), .ROI_Y_MAX(3)) dut_roi (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof),
        .frame_done(r_frame_done), .found(r_found), .x_min(r_x_min), .x_max(r_x_max),
        .y_min(r_y_min), .y_max(r_y_max), .x_ctr(r_x_ctr), .y_ctr(r_y_ctr),
        .pix_count(r_pix_count)
    );

    typedef struct {
        logic [47:0] mask;     // bit index = row*8 + col
        bit          gappy;
        int          found, xmin, xmax, ymin, ymax, xctr, yctr, cnt;
        int          r_found, r_cnt;
        bit          r_box;
        int          rxmin, rxmax, rymin, rymax, rxctr, ryctr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive n pixels from mask; frame_done must rise only after the last one when done_last.
    task automatic send_pixels(input logic [47:0] mask, input int n, input bit gappy,
                               input bit sof_first, input bit done_last);
        for (int i = 0; i < n; i++) begin
            if (gappy) begin
                int g = 0;
                while ($urandom_range(0, 1) == 1 && g < 4) begin
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                    @(posedge clk); #1;
                    chk("frame_done_in_gap", int'(frame_done), 0);
                    g++;
                end
            end
            in_valid = 1'b1;
            in_pixel = mask[i];
            in_sof   = sof_first && (i == 0);
            @(posedge clk); #1;
            chk($sformatf("frame_done_after_pixel%0d", i), int'(frame_done),
                (done_last && i == n - 1) ? 1 : 0);
        end
        in_sof = 1'b0;
    endtask

    task automatic chk_full(input string tag, input int f, input int x0, input int x1,
                            input int y0, input int y1, input int xc, input int yc, input int c);
        chk({tag, ".found"},     int'(found),     f);
        chk({tag, ".x_min"},     int'(x_min),     x0);
        chk({tag, ".x_max"},     int'(x_max),     x1);
        chk({tag, ".y_min"},     int'(y_min),     y0);
        chk({tag, ".y_max"},     int'(y_max),     y1);
        chk({tag, ".x_ctr"},     int'(x_ctr),     xc);
        chk({tag, ".y_ctr"},     int'(y_ctr),     yc);
        chk({tag, ".pix_count"}, int'(pix_count), c);
    endtask

    initial begin
        //         mask                 gap fd x0 x1 y0 y1 xc yc cnt rf rc box rx0 rx1 ry0 ry1 rxc ryc
        vecs[0] = '{48'h0008_2000_0400, 0, 1, 2, 5, 1, 4, 3, 2, 3,  0, 1, 0,  0,  0,  0,  0,  0,  0};
        vecs[1] = '{48'h8000_0000_0000, 0, 0, 2, 5, 1, 4, 3, 2, 1,  0, 0, 0,  0,  0,  0,  0,  0,  0};
        vecs[2] = '{48'h0008_2000_0400, 1, 1, 2, 5, 1, 4, 3, 2, 3,  0, 1, 0,  0,  0,  0,  0,  0,  0};
        vecs[3] = '{48'h0100_4010_0002, 0, 1, 0, 6, 0, 5, 3, 2, 4,  1, 2, 1,  4,  6,  2,  3,  5,  2};
        vecs[4] = '{48'h8000_0000_0001, 0, 1, 0, 7, 0, 5, 3, 2, 2,  0, 0, 1,  4,  6,  2,  3,  5,  2};
        vecs[5] = '{48'h0000_0000_0000, 1, 0, 0, 7, 0, 5, 3, 2, 0,  0, 0, 1,  4,  6,  2,  3,  5,  2};

        reset = 1'b1; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_full("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.frame_done", int'(frame_done), 0);
        chk("reset.roi_x_min", int'(r_x_min), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frames from the table.
        for (int k = 0; k < 6; k++) begin
            send_pixels(vecs[k].mask, 48, vecs[k].gappy, 1'b0, 1'b1);
            chk_full($sformatf("v%0d", k), vecs[k].found, vecs[k].xmin, vecs[k].xmax,
                     vecs[k].ymin, vecs[k].ymax, vecs[k].xctr, vecs[k].yctr, vecs[k].cnt);
            chk($sformatf("v%0d.roi_found", k), int'(r_found), vecs[k].r_found);
            chk($sformatf("v%0d.roi_pix_count", k), int'(r_pix_count), vecs[k].r_cnt);
            chk($sformatf("v%0d.roi_frame_done", k), int'(r_frame_done), 1);
            if (vecs[k].r_box) begin
                chk($sformatf("v%0d.roi_x_min", k), int'(r_x_min), vecs[k].rxmin);
                chk($sformatf("v%0d.roi_x_max", k), int'(r_x_max), vecs[k].rxmax);
                chk($sformatf("v%0d.roi_y_min", k), int'(r_y_min), vecs[k].rymin);
                chk($sformatf("v%0d.roi_y_max", k), int'(r_y_max), vecs[k].rymax);
                chk($sformatf("v%0d.roi_x_ctr", k), int'(r_x_ctr), vecs[k].rxctr);
                chk($sformatf("v%0d.roi_y_ctr", k), int'(r_y_ctr), vecs[k].ryctr);
            end
        end

        // Reset at pixel 20 of a frame with (1,1) set, then a clean frame.
        send_pixels(48'h0000_0000_0200, 20, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk_full("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset.frame_done", int'(frame_done), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midreset.idle_frame_done", int'(frame_done), 0);
        end
        send_pixels(48'h8040_0000_0000, 48, 1'b0, 1'b0, 1'b1);
        chk_full("after_reset", 1, 6, 7, 4, 5, 6, 4, 2);
        chk("after_reset.roi_pix_count", int'(r_pix_count), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // sof mid-frame (pixel 30) and on the end-of-frame pixel (pixel 47): partial frame dropped.
        for (int s = 0; s < 2; s++) begin
            int n = (s == 0) ? 30 : 47;
            send_pixels(48'h0000_0008_0000, n, 1'b0, 1'b0, 1'b0);
            send_pixels(48'h8000_0000_0001, 48, 1'b0, 1'b1, 1'b1);
            chk_full($sformatf("sof_at%0d", n), 1, 0, 7, 0, 5, 3, 2, 2);
            chk($sformatf("sof_at%0d.roi_pix_count", n), int'(r_pix_count), 0);
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("sof_at%0d.pulse_width", n), int'(frame_done), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
